// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for bin_to_bcd_seq.
//   master: producer/consumer side (drives in_valid, number, out_ready)
//   slave : converter side (drives in_ready, out_valid, bcd, digit_nz, neg, overflow)
// Parameters must match those of the attached converter.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 26,
  parameter int DIGITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      number;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     digit_nz;
  logic                  neg;
  logic                  overflow;

  modport master (
    output in_valid, number, out_ready,
    input  in_ready, out_valid, bcd, digit_nz, neg, overflow
  );

  modport slave (
    input  in_valid, number, out_ready,
    output in_ready, out_valid, bcd, digit_nz, neg, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble) method.
// One word is accepted per in_valid/in_ready handshake; the packed BCD result,
// a significant-digit mask, the sign and an overflow flag are presented with
// out_valid and held until out_ready.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, aborts any conversion in progress
//   bus  - bin_to_bcd_seq_if.slave: in_valid/in_ready/number in,
//          out_valid/out_ready/bcd/digit_nz/neg/overflow out
// Parameters:
//   BIN_W  input width (>=2), DIGITS output digits (>=1),
//   SIGNED 1 = treat number as two's complement and convert its magnitude.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 26,
  parameter int DIGITS = 8,
  parameter int SIGNED = 0
) (
  input logic               clk,
  input logic               rst,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BIN_W + BCD_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_reg;
  logic [SR_W-1:0]    shift_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sign_reg;
  logic               ov_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [DIGITS-1:0]  nz_reg;
  logic               neg_reg;
  logic               ovf_reg;

  logic [BCD_W-1:0]   adj_bcd;
  logic [SR_W-1:0]    shift_next;
  logic               ov_step;
  logic               in_neg;
  logic [BIN_W-1:0]   mag;
  logic [BCD_W-1:0]   result_bcd;
  logic [DIGITS-1:0]  result_nz;

  // Sign is only meaningful in signed mode; unsigned mode never negates.
  generate
    if (SIGNED != 0) begin : g_signed
      assign in_neg = bus.number[BIN_W-1];
    end else begin : g_unsigned
      assign in_neg = 1'b0;
    end
  endgenerate

  // Negating the most negative value wraps back to 100..0, which read as
  // unsigned is exactly its magnitude.
  assign mag = in_neg ? (~bus.number + BIN_W'(1)) : bus.number;

  // Add-3 correction on every BCD digit in parallel before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      logic [3:0] digit;
      assign digit = shift_reg[BIN_W + 4*gi +: 4];
      assign adj_bcd[4*gi +: 4] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    end
  endgenerate

  // A set MSB in the corrected BCD field would be shifted out, so the value
  // no longer fits in DIGITS digits.
  assign ov_step    = adj_bcd[BCD_W-1];
  assign shift_next = {adj_bcd[BCD_W-2:0], shift_reg[BIN_W-1:0], 1'b0};

  assign result_bcd = ov_reg ? {DIGITS{4'h9}} : shift_reg[SR_W-1 -: BCD_W];

  // Digit k is significant if it or any more significant digit is nonzero;
  // the ones digit is always shown.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nz
      if (gi == 0) begin : g_ones
        assign result_nz[gi] = 1'b1;
      end else begin : g_upper
        assign result_nz[gi] = |result_bcd[BCD_W-1 : 4*gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      sign_reg      <= 1'b0;
      ov_reg        <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      bcd_reg       <= '0;
      nz_reg        <= DIGITS'(1);
      neg_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            shift_reg    <= {{BCD_W{1'b0}}, mag};
            sign_reg     <= in_neg;
            ov_reg       <= 1'b0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          // One extra cycle after the last shift registers the result,
          // giving a fixed BIN_W+1 cycle latency from accept to out_valid.
          if (cnt_reg == CNT_W'(BIN_W)) begin
            bcd_reg       <= result_bcd;
            nz_reg        <= result_nz;
            neg_reg       <= sign_reg;
            ovf_reg       <= ov_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            shift_reg <= shift_next;
            if (ov_step) begin
              ov_reg <= 1'b1;
            end
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.bcd       = bcd_reg;
  assign bus.digit_nz  = nz_reg;
  assign bus.neg       = neg_reg;
  assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: defaults (26 bits, 8 digits, unsigned)
  bin_to_bcd_seq_if #(.BIN_W(26), .DIGITS(8)) ifa ();
  // B: 16 bits, 4 digits (overflow cases)
  bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) ifb ();
  // C: 8 bits, 3 digits, signed
  bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) ifc ();

  bin_to_bcd_seq #(.BIN_W(26), .DIGITS(8), .SIGNED(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3), .SIGNED(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          dut;
    logic [31:0] num;
    logic [31:0] bcd;
    logic [7:0]  nz;
    logic        neg;
    logic        ov;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each xfer task starts and ends 1 time unit after a rising edge.
  task automatic xfer_a(input logic [31:0] num, output logic [31:0] b, output logic [7:0] nz,
                        output logic ng, output logic ov, output int lat);
    int w = 0;
    while (!ifa.in_ready && w < 300) begin @(posedge clk); #1; w++; end
    ifa.in_valid = 1'b1; ifa.number = num[25:0];
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    lat = 0;
    while (!ifa.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    b = ifa.bcd; nz = ifa.digit_nz; ng = ifa.neg; ov = ifa.overflow;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
  endtask

  task automatic xfer_b(input logic [31:0] num, output logic [31:0] b, output logic [7:0] nz,
                        output logic ng, output logic ov, output int lat);
    int w = 0;
    while (!ifb.in_ready && w < 300) begin @(posedge clk); #1; w++; end
    ifb.in_valid = 1'b1; ifb.number = num[15:0];
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    lat = 0;
    while (!ifb.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    b = {16'h0, ifb.bcd}; nz = {4'h0, ifb.digit_nz}; ng = ifb.neg; ov = ifb.overflow;
    ifb.out_ready = 1'b1;
    @(posedge clk); #1;
    ifb.out_ready = 1'b0;
  endtask

  task automatic xfer_c(input logic [31:0] num, output logic [31:0] b, output logic [7:0] nz,
                        output logic ng, output logic ov, output int lat);
    int w = 0;
    while (!ifc.in_ready && w < 300) begin @(posedge clk); #1; w++; end
    ifc.in_valid = 1'b1; ifc.number = num[7:0];
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    b = {20'h0, ifc.bcd}; nz = {5'h0, ifc.digit_nz}; ng = ifc.neg; ov = ifc.overflow;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    logic [7:0]  nz;
    logic        ng;
    logic        ov;
    int          lat;
    int          exp_lat;
    int          w;

    //               dut num           bcd           nz     neg   ov
    vecs[0]  = '{0, 32'd0,        32'h00000000, 8'h01, 1'b0, 1'b0};
    vecs[1]  = '{0, 32'd12345678, 32'h12345678, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{0, 32'd67108863, 32'h67108863, 8'hFF, 1'b0, 1'b0};
    vecs[3]  = '{0, 32'd1000,     32'h00001000, 8'h0F, 1'b0, 1'b0};
    vecs[4]  = '{0, 32'd5,        32'h00000005, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{1, 32'd9999,     32'h00009999, 8'h0F, 1'b0, 1'b0};
    vecs[6]  = '{1, 32'd10000,    32'h00009999, 8'h0F, 1'b0, 1'b1};
    vecs[7]  = '{1, 32'd65535,    32'h00009999, 8'h0F, 1'b0, 1'b1};
    vecs[8]  = '{1, 32'd0,        32'h00000000, 8'h01, 1'b0, 1'b0};
    vecs[9]  = '{1, 32'd305,      32'h00000305, 8'h07, 1'b0, 1'b0};
    vecs[10] = '{2, 32'h80,       32'h00000128, 8'h07, 1'b1, 1'b0};
    vecs[11] = '{2, 32'hFF,       32'h00000001, 8'h01, 1'b1, 1'b0};
    vecs[12] = '{2, 32'h7F,       32'h00000127, 8'h07, 1'b0, 1'b0};
    vecs[13] = '{2, 32'h00,       32'h00000000, 8'h01, 1'b0, 1'b0};
    vecs[14] = '{2, 32'h9C,       32'h00000100, 8'h07, 1'b1, 1'b0};

    ifa.in_valid = 1'b0; ifa.number = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.number = '0; ifb.out_ready = 1'b0;
    ifc.in_valid = 1'b0; ifc.number = '0; ifc.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  {31'h0, ifa.in_ready}, 32'd1);
    check("rst_out_valid", {31'h0, ifa.out_valid}, 32'd0);
    check("rst_bcd",       ifa.bcd, 32'h0);
    check("rst_digit_nz",  {24'h0, ifa.digit_nz}, 32'h01);
    check("rst_overflow",  {31'h0, ifa.overflow}, 32'd0);
    check("rst_neg_c",     {31'h0, ifc.neg}, 32'd0);
    check("rst_nz_c",      {29'h0, ifc.digit_nz}, 32'h1);

    // Table-driven conversions
    for (int i = 0; i < 15; i++) begin
      case (vecs[i].dut)
        0:       begin xfer_a(vecs[i].num, b, nz, ng, ov, lat); exp_lat = 27; end
        1:       begin xfer_b(vecs[i].num, b, nz, ng, ov, lat); exp_lat = 17; end
        default: begin xfer_c(vecs[i].num, b, nz, ng, ov, lat); exp_lat = 9;  end
      endcase
      $display("vec %0d dut %0d num=%0h bcd=%0h nz=%0h neg=%0b ov=%0b lat=%0d",
               i, vecs[i].dut, vecs[i].num, b, nz, ng, ov, lat);
      check($sformatf("v%0d_bcd", i), b, vecs[i].bcd);
      check($sformatf("v%0d_nz", i), {24'h0, nz}, {24'h0, vecs[i].nz});
      check($sformatf("v%0d_neg", i), {31'h0, ng}, {31'h0, vecs[i].neg});
      check($sformatf("v%0d_ov", i), {31'h0, ov}, {31'h0, vecs[i].ov});
      check($sformatf("v%0d_latency", i), lat, exp_lat);
    end

    // Backpressure: result held for 5 cycles, new input ignored
    ifa.in_valid = 1'b1; ifa.number = 26'd12345678;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    w = 0;
    while (!ifa.out_valid && w < 200) begin @(posedge clk); #1; w++; end
    check("bp_latency", w, 27);
    for (int c = 0; c < 5; c++) begin
      ifa.in_valid = c[0]; ifa.number = 26'd7;
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", c), {31'h0, ifa.out_valid}, 32'd1);
      check($sformatf("bp%0d_in_ready", c), {31'h0, ifa.in_ready}, 32'd0);
      check($sformatf("bp%0d_bcd", c), ifa.bcd, 32'h12345678);
    end
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    check("bp_release_out_valid", {31'h0, ifa.out_valid}, 32'd0);
    check("bp_release_in_ready",  {31'h0, ifa.in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_not_queued_out_valid", {31'h0, ifa.out_valid}, 32'd0);
    check("bp_not_queued_in_ready",  {31'h0, ifa.in_ready}, 32'd1);
    check("bp_hold_bcd_idle",        ifa.bcd, 32'h12345678);
    $display("backpressure sequence done bcd=%0h", ifa.bcd);

    // Reset in the middle of a conversion
    ifa.in_valid = 1'b1; ifa.number = 26'd99;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("conv_in_ready",  {31'h0, ifa.in_ready}, 32'd0);
    check("conv_out_valid", {31'h0, ifa.out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", {31'h0, ifa.out_valid}, 32'd0);
    check("abort_in_ready",  {31'h0, ifa.in_ready}, 32'd1);
    check("abort_bcd",       ifa.bcd, 32'h0);
    check("abort_digit_nz",  {24'h0, ifa.digit_nz}, 32'h01);
    $display("reset abort done in_ready=%0b bcd=%0h", ifa.in_ready, ifa.bcd);
    xfer_a(32'd42, b, nz, ng, ov, lat);
    $display("post-abort num=42 bcd=%0h nz=%0h lat=%0d", b, nz, lat);
    check("post_abort_bcd", b, 32'h00000042);
    check("post_abort_nz",  {24'h0, nz}, 32'h03);
    check("post_abort_latency", lat, 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
